cpu_ifetch: RTL and testbench

Instruction fetch unit for the moxie core. It fetches 32-bit big-endian words from instruction memory into an 8-entry halfword queue. It presents the decoder with the oldest 16-bit opcode, plus the following 32-bit immediate when available, and retires halfwords when the decoder reports them consumed. It sits between the instruction memory port and the decode stage and supports a branch redirect that flushes the queue.

---
 rtl/cpu_ifetch.sv | 143 ++++++++++++++
 tb/tb_cpu_ifetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifetch.sv
// Moxie instruction fetch: one outstanding word fetch feeding an
// 8-entry halfword queue that the decoder drains 1 or 3 halfwords at a time.
module cpu_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h00001000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [15:0] ifid_insn_o,
    output logic        ifid_insn_valid_o,
    output logic [31:0] ifid_insn_data_o,
    output logic        ifid_insn_data_valid_o,
    input  logic        idif_used_insn_i,
    input  logic        idif_used_data_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pend_q, pend_d;
    logic [15:0] mem_q [8];
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [3:0]  count_q, count_d;
    logic        drop_q, drop_d;

    logic        pop_insn;
    logic        pop_data;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic        accept;
    logic [3:0]  left;
    logic [31:0] tgt_word;
    logic        unused_tgt_bit0;

    assign unused_tgt_bit0 = branch_target_i[0];
    assign tgt_word = {branch_target_i[31:2], 2'b00};

    // A 3-halfword pop is only legal when the immediate is already queued.
    assign pop_insn = idif_used_insn_i && (count_q != 4'd0);
    assign pop_data = pop_insn && idif_used_data_i && (count_q >= 4'd3);
    assign pop_n    = {pop_data, pop_insn};
    assign left     = count_q - 4'(pop_n);

    assign accept = (state_q == FETCH) && imem_ack_i && !branch_i;
    assign push_n = !accept ? 2'd0 : (drop_q ? 2'd1 : 2'd2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        head_d  = head_q + 3'(pop_n);
        tail_d  = tail_q + 3'(push_n);
        count_d = count_q + 4'(push_n) - 4'(pop_n);
        drop_d  = accept ? 1'b0 : drop_q;

        unique case (state_q)
            IDLE: begin
                if (left <= 4'd6) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    state_d = IDLE;
                    addr_d  = addr_q + 32'd4;
                end else if (branch_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack_i) begin
                    state_d = IDLE;
                    addr_d  = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // The in-flight address must stay stable, so a redirect that
        // arrives mid-fetch is parked in pend_q until the ack drains.
        if (branch_i) begin
            head_d  = 3'd0;
            tail_d  = 3'd0;
            count_d = 4'd0;
            drop_d  = branch_target_i[1];
            if (state_q == IDLE || imem_ack_i) begin
                state_d = IDLE;
                addr_d  = tgt_word;
            end else begin
                state_d = FLUSH;
                pend_d  = tgt_word;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            pend_q  <= RESET_PC;
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
            drop_q  <= 1'b0;
            for (int i = 0; i < 8; i++) mem_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            if (accept) begin
                if (drop_q) begin
                    mem_q[tail_q] <= imem_data_i[15:0];
                end else begin
                    mem_q[tail_q]        <= imem_data_i[31:16];
                    mem_q[tail_q + 3'd1] <= imem_data_i[15:0];
                end
            end
        end
    end

    assign imem_req_o  = (state_q != IDLE);
    assign imem_addr_o = addr_q;

    assign ifid_insn_o            = mem_q[head_q];
    assign ifid_insn_data_o       = {mem_q[head_q + 3'd1],
                                     mem_q[head_q + 3'd2]};
    assign ifid_insn_valid_o      = (count_q != 4'd0);
    assign ifid_insn_data_valid_o = (count_q >= 4'd3);

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch: directed scenarios then random traffic, all
// checked against a halfword-queue model of the fetch unit.
module tb_cpu_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic [15:0] insn;
    logic        ivld;
    logic [31:0] idata;
    logic        dvld;
    logic        ui = 1'b0;
    logic        ud = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] mq[$];
    bit          m_busy;
    bit          m_flush;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_pend;

    cpu_ifetch #(.RESET_PC(32'h00001000)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .imem_req_o             (req),
        .imem_addr_o            (addr),
        .imem_ack_i             (ack),
        .imem_data_i            (rdata),
        .ifid_insn_o            (insn),
        .ifid_insn_valid_o      (ivld),
        .ifid_insn_data_o       (idata),
        .ifid_insn_data_valid_o (dvld),
        .idif_used_insn_i       (ui),
        .idif_used_data_i       (ud),
        .branch_i               (br),
        .branch_target_i        (tgt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_flush = 0;
        m_drop  = 0;
        m_pc    = 32'h00001000;
        m_pend  = 32'h00001000;
    endtask

    task automatic model_step(bit u_i, bit u_d, bit b, logic [31:0] t,
                              bit a, logic [31:0] d);
        int n;
        int pop;
        n   = mq.size();
        pop = 0;
        if (u_i && n > 0) pop = (u_d && n >= 3) ? 3 : 1;
        if (b) begin
            mq.delete();
            m_drop = t[1];
            if (m_busy && !a) begin
                m_flush = 1;
                m_pend  = {t[31:2], 2'b00};
            end else begin
                m_busy  = 0;
                m_flush = 0;
                m_pc    = {t[31:2], 2'b00};
            end
        end else begin
            for (int k = 0; k < pop; k++) void'(mq.pop_front());
            if (m_busy && a) begin
                if (m_flush) begin
                    m_pc = m_pend;
                end else begin
                    if (!m_drop) mq.push_back(d[31:16]);
                    mq.push_back(d[15:0]);
                    m_drop = 0;
                    m_pc   = m_pc + 32'd4;
                end
                m_busy  = 0;
                m_flush = 0;
            end else if (!m_busy && (n - pop) <= 6) begin
                m_busy = 1;
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("req", {31'b0, req}, {31'b0, m_busy});
        if (m_busy) chk("addr", addr, m_pc);
        chk("ivld", {31'b0, ivld}, {31'b0, n >= 1});
        if (n >= 1) chk("insn", {16'b0, insn}, {16'b0, mq[0]});
        chk("dvld", {31'b0, dvld}, {31'b0, n >= 3});
        if (n >= 3) chk("data", idata, {mq[1], mq[2]});
    endtask

    task automatic cyc(bit u_i, bit u_d, bit b, logic [31:0] t,
                       bit a, logic [31:0] d);
        ui    = u_i;
        ud    = u_d;
        br    = b;
        tgt   = t;
        ack   = a;
        rdata = d;
        model_step(u_i, u_d, b, t, a, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic ack_cyc(logic [31:0] d);
        cyc(0, 0, 0, 32'h0, 1, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ui  = 0;
        ud  = 0;
        br  = 0;
        ack = 0;
        model_reset();
        @(negedge clk);
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'h00001000);
        chk("rst_ivld", {31'b0, ivld}, 32'd0);
        chk("rst_dvld", {31'b0, dvld}, 32'd0);
        chk("rst_insn", {16'b0, insn}, 32'd0);
        chk("rst_data", idata, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bit u_i;
        bit u_d;
        bit b;
        bit a;

        // streaming from reset
        do_reset();
        idle_cyc();
        chk("s_addr0", addr, 32'h00001000);
        ack_cyc(32'h01200000);
        idle_cyc();
        chk("s_addr1", addr, 32'h00001004);
        ack_cyc(32'h12345678);
        chk("s_insn", {16'b0, insn}, 32'h00000120);
        chk("s_data", idata, 32'h00001234);
        chk("s_dvld", {31'b0, dvld}, 32'd1);
        cyc(1, 1, 0, 32'h0, 0, 32'h0);
        chk("s_pop3", {16'b0, insn}, 32'h00005678);
        chk("s_cnt1", {31'b0, dvld}, 32'd0);

        // fill to full, then simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_cyc();
            chk("f_addr", addr, 32'h00001000 + 32'(4 * i));
            ack_cyc($urandom);
        end
        idle_cyc();
        chk("f_full", {31'b0, req}, 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 32'h0);
        chk("f_cnt7", {31'b0, req}, 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 32'h0);
        chk("f_cnt6", {31'b0, req}, 32'd1);
        chk("f_addr4", addr, 32'h00001010);
        cyc(1, 0, 0, 32'h0, 1, 32'hA1B2C3D4);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 32'h0, 0, 32'h0);
        chk("f_drain", {31'b0, ivld}, 32'd0);

        // unaligned branch from IDLE
        do_reset();
        idle_cyc();
        ack_cyc(32'h11112222);
        cyc(0, 0, 1, 32'h00002002, 0, 32'h0);
        chk("u_empty", {31'b0, ivld}, 32'd0);
        idle_cyc();
        chk("u_addr", addr, 32'h00002000);
        ack_cyc(32'hAAAABBBB);
        chk("u_insn", {16'b0, insn}, 32'h0000BBBB);
        chk("u_one", {31'b0, dvld}, 32'd0);

        // branch while a fetch is outstanding
        do_reset();
        idle_cyc();
        ack_cyc(32'h00010002);
        idle_cyc();
        ack_cyc(32'h00030004);
        idle_cyc();
        chk("b_addr", addr, 32'h00001008);
        cyc(0, 0, 1, 32'h00003000, 0, 32'h0);
        chk("b_hold0", addr, 32'h00001008);
        idle_cyc();
        idle_cyc();
        chk("b_hold2", addr, 32'h00001008);
        ack_cyc(32'hDEADBEEF);
        chk("b_disc", {31'b0, ivld}, 32'd0);
        idle_cyc();
        chk("b_new", addr, 32'h00003000);

        // illegal consumes
        do_reset();
        idle_cyc();
        ack_cyc(32'hCAFE0001);
        cyc(1, 1, 0, 32'h0, 0, 32'h0);
        chk("i_pop1", {16'b0, insn}, 32'h00000001);
        cyc(1, 0, 0, 32'h0, 0, 32'h0);
        cyc(1, 1, 0, 32'h0, 0, 32'h0);
        chk("i_pop0", {31'b0, ivld}, 32'd0);

        // asynchronous reset with a fetch in flight, then a late ack
        #2 rst = 1'b1;
        #1 chk("r_async", {31'b0, req}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ack_cyc(32'h55556666);
        chk("r_late", {31'b0, ivld}, 32'd0);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            u_i = ($urandom % 2) == 0;
            u_d = u_i && (($urandom % 2) == 0);
            b   = ($urandom % 25) == 0;
            a   = m_busy ? (($urandom % 3) == 0)
                         : (($urandom % 40) == 0);
            cyc(u_i, u_d, b, $urandom, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
